arp_tbl_access_arbiter: RTL

//  Shares the single ARP-table access port (tbl_rd/wr req/addr/data/ack) between two requesters:

---
 rtl/arp_tbl_access_arbiter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/arp_tbl_access_arbiter.sv
// Round-robin arbiter that shares the ARP-table access port between the host
// register interface (client 0) and the ARP-learning engine (client 1). Only one
// table transaction is in flight at a time. Each transaction has an ack timeout
// that completes it with an error flag.
module arp_tbl_access_arbiter #(
    parameter int unsigned DATA_WIDTH     = 96,
    parameter int unsigned ADDR_WIDTH     = 5,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned COUNT_WIDTH    = 32
) (
    input  logic                   AXI_ACLK,
    input  logic                   reset,
    input  logic                   c0_req,
    input  logic                   c0_wr,
    input  logic [ADDR_WIDTH-1:0]  c0_addr,
    input  logic [DATA_WIDTH-1:0]  c0_wdata,
    output logic                   c0_ack,
    output logic                   c0_err,
    output logic [DATA_WIDTH-1:0]  c0_rdata,
    input  logic                   c1_req,
    input  logic                   c1_wr,
    input  logic [ADDR_WIDTH-1:0]  c1_addr,
    input  logic [DATA_WIDTH-1:0]  c1_wdata,
    output logic                   c1_ack,
    output logic                   c1_err,
    output logic [DATA_WIDTH-1:0]  c1_rdata,
    output logic                   tbl_rd_req,
    output logic                   tbl_wr_req,
    output logic [ADDR_WIDTH-1:0]  tbl_rd_addr,
    output logic [ADDR_WIDTH-1:0]  tbl_wr_addr,
    output logic [DATA_WIDTH-1:0]  tbl_wr_data,
    input  logic [DATA_WIDTH-1:0]  tbl_rd_data,
    input  logic                   tbl_rd_ack,
    input  logic                   tbl_wr_ack,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] timeout_count
);

    localparam int unsigned WAIT_CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   last_grant_q, last_grant_d;
    logic                   gnt_q, gnt_d;
    logic                   wr_q, wr_d;
    logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic                   tbl_rd_req_q, tbl_rd_req_d;
    logic                   tbl_wr_req_q, tbl_wr_req_d;
    logic [ADDR_WIDTH-1:0]  tbl_addr_q, tbl_addr_d;
    logic [DATA_WIDTH-1:0]  tbl_wr_data_q, tbl_wr_data_d;
    logic                   c0_ack_q, c0_ack_d;
    logic                   c0_err_q, c0_err_d;
    logic [DATA_WIDTH-1:0]  c0_rdata_q, c0_rdata_d;
    logic                   c1_ack_q, c1_ack_d;
    logic                   c1_err_q, c1_err_d;
    logic [DATA_WIDTH-1:0]  c1_rdata_q, c1_rdata_d;
    logic                   busy_q, busy_d;
    logic [COUNT_WIDTH-1:0] timeout_count_q, timeout_count_d;

    // Completion bundle produced in WAIT, steered to the granted client
    logic                   fin_en;
    logic                   fin_err;
    logic [DATA_WIDTH-1:0]  fin_rdata;

    // Arbitration choice: a tie goes to the client that was not served last
    logic                   sel_gnt_c;
    logic                   ack_hit_c;

    assign sel_gnt_c = (c0_req && c1_req) ? ~last_grant_q : c1_req;
    assign ack_hit_c = wr_q ? tbl_wr_ack : tbl_rd_ack;

    // Next-state and registered-output computation
    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        gnt_d           = gnt_q;
        wr_d            = wr_q;
        wait_cnt_d      = wait_cnt_q;
        tbl_rd_req_d    = 1'b0;
        tbl_wr_req_d    = 1'b0;
        tbl_addr_d      = tbl_addr_q;
        tbl_wr_data_d   = tbl_wr_data_q;
        c0_ack_d        = 1'b0;
        c0_err_d        = c0_err_q;
        c0_rdata_d      = c0_rdata_q;
        c1_ack_d        = 1'b0;
        c1_err_d        = c1_err_q;
        c1_rdata_d      = c1_rdata_q;
        timeout_count_d = timeout_count_q;
        fin_en          = 1'b0;
        fin_err         = 1'b0;
        fin_rdata       = '0;

        unique case (state_q)
            S_IDLE: begin
                if (c0_req || c1_req) begin
                    gnt_d         = sel_gnt_c;
                    wr_d          = sel_gnt_c ? c1_wr : c0_wr;
                    tbl_addr_d    = sel_gnt_c ? c1_addr : c0_addr;
                    tbl_wr_data_d = sel_gnt_c ? c1_wdata : c0_wdata;
                    tbl_wr_req_d  = wr_d;
                    tbl_rd_req_d  = ~wr_d;
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (ack_hit_c) begin
                    fin_en    = 1'b1;
                    fin_err   = 1'b0;
                    fin_rdata = wr_q ? (gnt_q ? c1_rdata_q : c0_rdata_q) : tbl_rd_data;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    fin_en    = 1'b1;
                    fin_err   = 1'b1;
                    fin_rdata = '0;
                    if (timeout_count_q != {COUNT_WIDTH{1'b1}}) begin
                        timeout_count_d = timeout_count_q + COUNT_WIDTH'(1);
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
                end
                if (fin_en) begin
                    state_d = S_DONE;
                    if (gnt_q) begin
                        c1_ack_d   = 1'b1;
                        c1_err_d   = fin_err;
                        c1_rdata_d = fin_rdata;
                    end else begin
                        c0_ack_d   = 1'b1;
                        c0_err_d   = fin_err;
                        c0_rdata_d = fin_rdata;
                    end
                end
            end
            S_DONE: begin
                last_grant_d = gnt_q;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge AXI_ACLK) begin
        if (reset) begin
            state_q         <= S_IDLE;
            last_grant_q    <= 1'b1;
            gnt_q           <= 1'b0;
            wr_q            <= 1'b0;
            wait_cnt_q      <= '0;
            tbl_rd_req_q    <= 1'b0;
            tbl_wr_req_q    <= 1'b0;
            tbl_addr_q      <= '0;
            tbl_wr_data_q   <= '0;
            c0_ack_q        <= 1'b0;
            c0_err_q        <= 1'b0;
            c0_rdata_q      <= '0;
            c1_ack_q        <= 1'b0;
            c1_err_q        <= 1'b0;
            c1_rdata_q      <= '0;
            busy_q          <= 1'b0;
            timeout_count_q <= '0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            gnt_q           <= gnt_d;
            wr_q            <= wr_d;
            wait_cnt_q      <= wait_cnt_d;
            tbl_rd_req_q    <= tbl_rd_req_d;
            tbl_wr_req_q    <= tbl_wr_req_d;
            tbl_addr_q      <= tbl_addr_d;
            tbl_wr_data_q   <= tbl_wr_data_d;
            c0_ack_q        <= c0_ack_d;
            c0_err_q        <= c0_err_d;
            c0_rdata_q      <= c0_rdata_d;
            c1_ack_q        <= c1_ack_d;
            c1_err_q        <= c1_err_d;
            c1_rdata_q      <= c1_rdata_d;
            busy_q          <= busy_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    assign c0_ack        = c0_ack_q;
    assign c0_err        = c0_err_q;
    assign c0_rdata      = c0_rdata_q;
    assign c1_ack        = c1_ack_q;
    assign c1_err        = c1_err_q;
    assign c1_rdata      = c1_rdata_q;
    assign tbl_rd_req    = tbl_rd_req_q;
    assign tbl_wr_req    = tbl_wr_req_q;
    assign tbl_rd_addr   = tbl_addr_q;
    assign tbl_wr_addr   = tbl_addr_q;
    assign tbl_wr_data   = tbl_wr_data_q;
    assign busy          = busy_q;
    assign timeout_count = timeout_count_q;

endmodule
